usb_uart_tx_engine: RTL and testbench
=====================================

USB_UART_TX_ENGINE -- requirements
Module: usb_uart_tx_engine

Interface
REQ-001 Parameter: CLK_FREQ, default 60_000_000, PHY clock frequency in Hz.
REQ-002 PHY_CLKOUT  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESETN_IN  in  1  asynchronous, active-low reset.
REQ-004 uart_en  in  1  DTR-derived enable from the line-coding block.
REQ-005 cfg_baud  in  32  baud rate in bit/s (dwDTERate).
REQ-006 cfg_stop  in  8  stop bits: 0 = 1, 1 = 1.5, 2 = 2; other values = 1.
REQ-007 cfg_parity  in  8  parity: 0 none, 1 odd, 2 even, 3 mark, 4 space; other values = none.
REQ-008 cfg_data_bits  in  8  data bits: 5, 6, 7 or 8; other values = 8.
REQ-009 tx_data, tx_valid, tx_ready  in 8, in 1, out 1  byte stream from the USB bulk-OUT endpoint; valid/ready handshake.
REQ-010 uart_tx  out  1  serial line; idles high.
REQ-011 tx_busy  out  1  high while a frame is on the line.
REQ-012 cfg_err  out  1  sticky high after cfg_baud = 0 is seen; cleared by the next nonzero baud.

Function
REQ-013 The block SHALL compute the half-bit divisor hdiv = floor(CLK_FREQ / (2*cfg_baud)) with a 32-cycle sequential restoring divider; results below 1 SHALL be clamped to 1.
REQ-014 A recompute SHALL start the cycle after cfg_baud differs from the last latched baud, and once after reset; a baud change during a recompute SHALL restart it.
REQ-015 cfg_baud = 0 SHALL NOT start a recompute: the previous hdiv is kept and cfg_err is set.
REQ-016 tx_ready SHALL be high only when all hold: uart_en = 1, TX FSM in IDLE, no recompute in progress.
REQ-017 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both high.
REQ-018 Configuration (data bits, parity, stop bits, hdiv) SHALL be latched at byte acceptance; later changes affect only subsequent frames.
REQ-019 TX FSM states: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
REQ-020 uart_tx SHALL go low on the first cycle after acceptance.
REQ-021 Each start, data and parity bit SHALL last exactly 2*hdiv cycles.
REQ-022 Stop duration SHALL be 2*hdiv cycles (1 stop bit), 3*hdiv (1.5) or 4*hdiv (2).
REQ-023 Data SHALL be sent LSB first, bits [N-1:0] only.
REQ-024 Parity bit values: odd = XNOR of the sent bits; even = XOR of the sent bits; mark = 1; space = 0.
REQ-025 tx_busy SHALL be high from the cycle uart_tx goes low until the last stop cycle inclusive; the FSM SHALL return to IDLE on the following cycle.
REQ-026 Back-to-back frames: tx_ready SHALL reassert in the IDLE cycle, giving a minimum gap of 1 idle-high cycle between frames.
REQ-027 If uart_en deasserts mid-frame, the current frame SHALL complete and no further byte SHALL be accepted.
REQ-028 A baud change mid-frame SHALL NOT alter the frame in flight; the recompute runs in parallel and tx_ready stays low until it finishes.

Reset
REQ-029 While RESETN_IN = 0: uart_tx = 1, tx_ready = 0, tx_busy = 0, cfg_err = 0, FSM = IDLE, latched baud = 0, hdiv = 1.
REQ-030 Reset asserted mid-frame SHALL drive uart_tx high immediately (asynchronously).
REQ-031 The first recompute SHALL begin on the first clock after reset release.

Structure
REQ-032 The following SHALL live in the shared package uart_pkg: state encodings, parity codes, stop codes, and the default data-bit width.
REQ-033 The divider SHALL be a separate sub-module, uart_baud_div, with start/busy/done handshake and dividend/divisor/quotient ports.

Verification (CLK_FREQ = 60_000_000)
REQ-034 cfg_baud = 3_000_000, 8N1, send 0x55: hdiv = 10; uart_tx shows 0,1,0,1,0,1,0,1,0,1 at 20 cycles per bit, then a 20-cycle stop; tx_busy high for 200 cycles.
REQ-035 cfg_baud = 3_000_000, 7 data bits, even parity, 2 stop bits, send 0x41: data 1,0,0,0,0,0,1, parity 0, stop high for 40 cycles; with odd parity, parity bit = 1.
REQ-036 cfg_baud = 115200: after reset, tx_ready stays low for about 33 cycles; hdiv = 260, giving 520-cycle bits; with 1.5 stop bits, stop lasts 780 cycles.
REQ-037 Change cfg_baud from 3_000_000 to 1_500_000 at data bit 3 of a frame: the current frame keeps 20-cycle bits; the next frame uses 40-cycle bits; tx_ready stays low until the recompute is done.
REQ-038 cfg_baud = 0: cfg_err = 1 and hdiv stays 10; drop uart_en mid-frame: the frame completes and tx_ready stays 0; pulse RESETN_IN low mid-frame: uart_tx = 1 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and decode helpers for the UART transmit path.
// Raw line-coding bytes are mapped to legal values here so every user decodes them identically.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_ODD   = 3'd1,
      PAR_EVEN  = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_e;

   typedef enum logic [1:0] {
      STOP_1   = 2'd0,
      STOP_1P5 = 2'd1,
      STOP_2   = 2'd2
   } stop_e;

   localparam logic [3:0] DATA_BITS_DEF = 4'd8;

   function automatic parity_e decode_parity(input logic [7:0] code);
      case (code)
         8'd1:    return PAR_ODD;
         8'd2:    return PAR_EVEN;
         8'd3:    return PAR_MARK;
         8'd4:    return PAR_SPACE;
         default: return PAR_NONE;
      endcase
   endfunction

   function automatic stop_e decode_stop(input logic [7:0] code);
      case (code)
         8'd1:    return STOP_1P5;
         8'd2:    return STOP_2;
         default: return STOP_1;
      endcase
   endfunction

   function automatic logic [3:0] decode_bits(input logic [7:0] code);
      if (code >= 8'd5 && code <= 8'd8) return code[3:0];
      return DATA_BITS_DEF;
   endfunction

   function automatic logic [7:0] data_mask(input logic [3:0] nbits);
      return 8'hFF >> (4'd8 - nbits);
   endfunction

endpackage

// File: rtl/uart_baud_div.sv
// 32-cycle restoring divider: quotient = dividend / divisor, one quotient bit per clock.
// A start while busy reloads the operands and restarts from scratch.
module uart_baud_div (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [32:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
);

   logic [32:0] rem_q, rem_d;
   logic [32:0] dsr_q, dsr_d;
   logic [31:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [33:0] shifted;
   logic [33:0] diff;

   always_comb begin
      rem_d   = rem_q;
      dsr_d   = dsr_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shifted = {rem_q, quo_q[31]};
      // remainder stays below divisor, so bit 33 of diff is a clean borrow flag
      diff    = shifted - {1'b0, dsr_q};
      if (start) begin
         rem_d  = '0;
         dsr_d  = divisor;
         quo_d  = dividend;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = diff[33] ? shifted[32:0] : diff[32:0];
         quo_d = {quo_q[30:0], ~diff[33]};
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         dsr_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/usb_uart_tx_engine.sv
// UART transmitter fed by the USB bulk-OUT byte stream; the half-bit divisor is
// recomputed from the host baud rate whenever it changes.
module usb_uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 60_000_000
) (
   input  logic        PHY_CLKOUT,
   input  logic        RESETN_IN,
   input  logic        uart_en,
   input  logic [31:0] cfg_baud,
   input  logic [7:0]  cfg_stop,
   input  logic [7:0]  cfg_parity,
   input  logic [7:0]  cfg_data_bits,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic        cfg_err
);

   localparam logic [31:0] DIVIDEND = 32'(CLK_FREQ);

   tx_state_e   state_q, state_d;
   logic [31:0] baud_q, baud_d;
   logic [31:0] hdiv_q, hdiv_d;
   logic [31:0] hdiv_l_q, hdiv_l_d;
   logic        cfg_err_q, cfg_err_d;
   logic [7:0]  data_q, data_d;
   logic [3:0]  nbits_q, nbits_d;
   parity_e     par_q, par_d;
   stop_e       stop_q, stop_d;
   logic [34:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;

   logic        baud_change, div_busy, div_done, accept, par_bit, last_cycle;
   logic [31:0] div_quo;
   logic [34:0] bit_len, stop_len, cur_len;

   uart_baud_div u_div (
      .clk      (PHY_CLKOUT),
      .rst_n    (RESETN_IN),
      .start    (baud_change),
      .dividend (DIVIDEND),
      .divisor  ({cfg_baud, 1'b0}),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      baud_change = (cfg_baud != 32'd0) && (cfg_baud != baud_q);
      baud_d      = baud_change ? cfg_baud : baud_q;
      cfg_err_d   = (cfg_baud == 32'd0);
      hdiv_d      = hdiv_q;
      if (div_done) hdiv_d = (div_quo == 32'd0) ? 32'd1 : div_quo;
      // done is included so a frame never starts with the pre-update divisor
      tx_ready = RESETN_IN && uart_en && (state_q == ST_IDLE) &&
                 !div_busy && !div_done && !baud_change;
      accept   = tx_ready && tx_valid;
   end

   always_comb begin
      bit_len = {2'b00, hdiv_l_q, 1'b0};
      case (stop_q)
         STOP_1P5: stop_len = {2'b00, hdiv_l_q, 1'b0} + {3'b000, hdiv_l_q};
         STOP_2:   stop_len = {1'b0, hdiv_l_q, 2'b00};
         default:  stop_len = bit_len;
      endcase
      cur_len    = (state_q == ST_STOP) ? stop_len : bit_len;
      last_cycle = (cnt_q == cur_len - 35'd1);
      case (par_q)
         PAR_ODD:  par_bit = ~^data_q;
         PAR_EVEN: par_bit = ^data_q;
         PAR_MARK: par_bit = 1'b1;
         default:  par_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      nbits_d  = nbits_q;
      par_d    = par_q;
      stop_d   = stop_q;
      hdiv_l_d = hdiv_l_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      if (state_q == ST_IDLE) begin
         if (accept) begin
            // unused upper bits are zeroed so parity can fold the whole byte
            data_d   = tx_data & data_mask(decode_bits(cfg_data_bits));
            nbits_d  = decode_bits(cfg_data_bits);
            par_d    = decode_parity(cfg_parity);
            stop_d   = decode_stop(cfg_stop);
            hdiv_l_d = hdiv_q;
            cnt_d    = '0;
            idx_d    = '0;
            state_d  = ST_START;
         end
      end else begin
         cnt_d = cnt_q + 35'd1;
         if (last_cycle) begin
            cnt_d = '0;
            case (state_q)
               ST_START: state_d = ST_DATA;
               ST_DATA: begin
                  if (idx_q == 3'(nbits_q - 4'd1))
                     state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                  else
                     idx_d = idx_q + 3'd1;
               end
               ST_PARITY: state_d = ST_STOP;
               default:   state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      case (state_q)
         ST_START:  uart_tx = 1'b0;
         ST_DATA:   uart_tx = data_q[idx_q];
         ST_PARITY: uart_tx = par_bit;
         default:   uart_tx = 1'b1;
      endcase
   end

   always_ff @(posedge PHY_CLKOUT or negedge RESETN_IN) begin
      if (!RESETN_IN) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         hdiv_q    <= 32'd1;
         hdiv_l_q  <= 32'd1;
         cfg_err_q <= 1'b0;
         data_q    <= '0;
         nbits_q   <= DATA_BITS_DEF;
         par_q     <= PAR_NONE;
         stop_q    <= STOP_1;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         hdiv_q    <= hdiv_d;
         hdiv_l_q  <= hdiv_l_d;
         cfg_err_q <= cfg_err_d;
         data_q    <= data_d;
         nbits_q   <= nbits_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign tx_busy = (state_q != ST_IDLE);
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_usb_uart_tx_engine.sv
// Randomised bench for usb_uart_tx_engine: a per-cycle waveform model built from
// the frame rules is compared against the line every cycle, plus directed literal cases.
module tb_usb_uart_tx_engine;

   localparam int unsigned CLK_FREQ = 60_000_000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        uart_en = 1'b0;
   logic [31:0] cfg_baud = '0;
   logic [7:0]  cfg_stop = '0;
   logic [7:0]  cfg_parity = '0;
   logic [7:0]  cfg_data_bits = 8'd8;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, uart_tx, tx_busy, cfg_err;

   usb_uart_tx_engine #(.CLK_FREQ(CLK_FREQ)) dut (
      .PHY_CLKOUT    (clk),
      .RESETN_IN     (rst_n),
      .uart_en       (uart_en),
      .cfg_baud      (cfg_baud),
      .cfg_stop      (cfg_stop),
      .cfg_parity    (cfg_parity),
      .cfg_data_bits (cfg_data_bits),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .uart_tx       (uart_tx),
      .tx_busy       (tx_busy),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        exp_q[$];
   logic [31:0] m_baud = '0;
   int          m_since = 0;
   logic        m_err = 1'b0;

   function automatic int model_hdiv(input logic [31:0] b);
      longint unsigned q;
      if (b == 0) return 1;
      q = longint'(CLK_FREQ) / (2 * longint'(b));
      return (q == 0) ? 1 : int'(q);
   endfunction

   task automatic push_frame(input logic [7:0] d, input logic [7:0] bits_c,
                             input logic [7:0] par_c, input logic [7:0] stop_c, input int h);
      int n, ones, mult;
      logic pb;
      n = (bits_c >= 5 && bits_c <= 8) ? int'(bits_c) : 8;
      ones = 0;
      repeat (2 * h) exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         repeat (2 * h) exp_q.push_back(d[i]);
         ones += d[i];
      end
      if (par_c >= 1 && par_c <= 4) begin
         case (par_c)
            8'd1:    pb = (ones % 2 == 0);
            8'd2:    pb = (ones % 2 == 1);
            8'd3:    pb = 1'b1;
            default: pb = 1'b0;
         endcase
         repeat (2 * h) exp_q.push_back(pb);
      end
      mult = (stop_c == 8'd1) ? 3 : (stop_c == 8'd2) ? 4 : 2;
      repeat (mult * h) exp_q.push_back(1'b1);
   endtask

   always @(negedge clk) begin
      logic busy_cycle;
      logic e;
      busy_cycle = 1'b0;
      if (!rst_n) begin
         check("rst_uart_tx", uart_tx, 1);
         check("rst_tx_ready", tx_ready, 0);
         check("rst_tx_busy", tx_busy, 0);
         check("rst_cfg_err", cfg_err, 0);
         exp_q.delete();
         m_baud  = '0;
         m_since = 0;
         m_err   = 1'b0;
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            busy_cycle = 1'b1;
            check("uart_tx", uart_tx, e);
            check("tx_busy", tx_busy, 1);
         end else begin
            check("idle_uart_tx", uart_tx, 1);
            check("idle_tx_busy", tx_busy, 0);
         end
         check("cfg_err", cfg_err, m_err);
         if (cfg_baud != 0 && cfg_baud != m_baud) begin
            m_baud  = cfg_baud;
            m_since = 0;
         end else if (m_since < 100000) begin
            m_since++;
         end
         if (busy_cycle || !uart_en || m_since <= 32)
            check("tx_ready_low", tx_ready, 0);
         else if (m_since >= 40)
            check("tx_ready_high", tx_ready, 1);
         m_err = (cfg_baud == 0);
         if (tx_valid && tx_ready)
            push_frame(tx_data, cfg_data_bits, cfg_parity, cfg_stop, model_hdiv(m_baud));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] d);
      int n;
      tx_data  = d;
      tx_valid = 1'b1;
      #1;
      n = 0;
      while (!tx_ready && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) begin
         check("send_timeout", 0, 1);
         tx_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         tx_valid = 1'b0;
      end
   endtask

   task automatic wait_frame(input int slot, input int chg_at, input logic [31:0] nb,
                             input logic drop, output int busy, output logic [15:0] bits);
      int guard;
      busy  = 0;
      bits  = '0;
      guard = 0;
      while (guard < 20000) begin
         if (tx_busy) begin
            busy++;
            if (slot > 0 && ((busy - 1) % slot) == slot / 2 && (busy - 1) / slot < 16)
               bits[(busy - 1) / slot] = uart_tx;
         end else if (busy > 0) begin
            break;
         end
         if (busy == chg_at) begin
            if (drop) uart_en = 1'b0;
            else      cfg_baud = nb;
         end
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20000) check("frame_timeout", 0, 1);
   endtask

   task automatic frame_test(input string nm, input logic [7:0] d, input logic [7:0] nbits,
                             input logic [7:0] par, input logic [7:0] stp, input int slot,
                             input int nslots, input int exp_busy, input logic [15:0] exp_bits,
                             input int chg_at, input logic [31:0] nb, input logic drop);
      int busy;
      logic [15:0] bits, mask;
      cfg_data_bits = nbits;
      cfg_parity    = par;
      cfg_stop      = stp;
      send(d);
      wait_frame(slot, chg_at, nb, drop, busy, bits);
      mask = 16'((32'd1 << nslots) - 1);
      check({nm, "_busy"}, busy, exp_busy);
      check({nm, "_bits"}, bits & mask, exp_bits);
   endtask

   localparam int NB = 6;
   logic [31:0] baud_tab [NB] = '{32'd3_000_000, 32'd2_000_000, 32'd6_000_000,
                                  32'd1_500_000, 32'd40_000_000, 32'd1_000_000};
   logic [7:0]  bits_tab [6]  = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd9};

   initial begin
      int lat, acc, busy;
      logic [15:0] bits;

      check("model_hdiv_3M", model_hdiv(32'd3_000_000), 10);
      check("model_hdiv_115200", model_hdiv(32'd115200), 260);
      check("model_hdiv_clamp", model_hdiv(32'd40_000_000), 1);

      cfg_baud = 32'd3_000_000;
      uart_en  = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      lat = 0;
      while (!tx_ready && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ready_latency_in_range", (lat >= 30 && lat <= 40), 1);

      frame_test("f55_8n1", 8'h55, 8'd8, 8'd0, 8'd0, 20, 10, 200, 16'h02AA, -1, 0, 1'b0);
      frame_test("f41_7e2", 8'h41, 8'd7, 8'd2, 8'd2, 20, 11, 220, 16'h0682, -1, 0, 1'b0);
      frame_test("f41_7o2", 8'h41, 8'd7, 8'd1, 8'd2, 20, 11, 220, 16'h0782, -1, 0, 1'b0);
      frame_test("f00_8m1", 8'h00, 8'd8, 8'd3, 8'd0, 20, 11, 220, 16'h0600, -1, 0, 1'b0);
      frame_test("fff_5n1", 8'hFF, 8'd5, 8'd0, 8'd0, 20, 7, 140, 16'h007E, -1, 0, 1'b0);

      frame_test("midbaud_cur", 8'h55, 8'd8, 8'd0, 8'd0, 20, 10, 200, 16'h02AA,
                 85, 32'd1_500_000, 1'b0);
      frame_test("midbaud_next", 8'h55, 8'd8, 8'd0, 8'd0, 40, 10, 400, 16'h02AA, -1, 0, 1'b0);

      cfg_baud = 32'd115200;
      frame_test("f0f_115k_1p5", 8'h0F, 8'd8, 8'd0, 8'd1, 520, 10, 5460, 16'h021E, -1, 0, 1'b0);

      cfg_baud = 32'd3_000_000;
      frame_test("back_to_3M", 8'h55, 8'd8, 8'd0, 8'd0, 20, 10, 200, 16'h02AA, -1, 0, 1'b0);
      cfg_baud = 32'd0;
      repeat (2) @(posedge clk);
      #1 check("cfg_err_set", cfg_err, 1);
      frame_test("baud0_keeps_hdiv", 8'h55, 8'd8, 8'd0, 8'd0, 20, 10, 200, 16'h02AA, -1, 0, 1'b0);
      cfg_baud = 32'd3_000_000;
      repeat (2) @(posedge clk);
      #1 check("cfg_err_clear", cfg_err, 0);

      frame_test("en_drop", 8'h55, 8'd8, 8'd0, 8'd0, 20, 10, 200, 16'h02AA, 85, 0, 1'b1);
      tx_valid = 1'b1;
      acc = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (tx_busy) acc++;
      end
      check("en_low_no_accept", acc, 0);
      tx_valid = 1'b0;
      uart_en  = 1'b1;

      send(8'h55);
      repeat (50) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_rst_uart_tx", uart_tx, 1);
      check("async_rst_tx_busy", tx_busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) != 0) cfg_baud = baud_tab[$urandom_range(0, NB - 1)];
         cfg_data_bits = bits_tab[$urandom_range(0, 5)];
         cfg_parity    = 8'($urandom_range(0, 6));
         cfg_stop      = 8'($urandom_range(0, 3));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         send(8'($urandom));
         if ($urandom_range(0, 4) == 0)
            wait_frame(0, $urandom_range(1, 30), baud_tab[$urandom_range(0, NB - 1)], 1'b0,
                       busy, bits);
         else
            wait_frame(0, -1, 0, 1'b0, busy, bits);
      end

      lat = 0;
      while (exp_q.size() > 0 && lat < 20000) begin
         @(posedge clk); #1;
         lat++;
      end
      check("model_drained", exp_q.size(), 0);
      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
